fmdll_lock_ctrl: RTL and testbench

//  Delay-line control loop that consumes the N/M cycle counters of the FMDLL.

---
 rtl/fmdll_pkg.sv | 25 ++
 rtl/fmdll_win_sampler.sv | 45 ++++
 rtl/fmdll_lock_ctrl.sv | 157 +++++++++++++++
 tb/tb_fmdll_lock_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/fmdll_pkg.sv
// Shared encodings for the FMDLL lock controller: FSM states, window decisions
// and the S-versus-N classification helper.
package fmdll_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_TRACK  = 2'd2,
    ST_LOCKED = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    DEC_HIT = 2'd0,
    DEC_INC = 2'd1,
    DEC_DEC = 2'd2
  } dec_e;

  // clk_out ran too many cycles -> more delay (INC); too few -> less delay (DEC).
  function automatic dec_e classify(input logic [3:0] s, input logic [3:0] n);
    if (s > n) return DEC_INC;
    if (s < n) return DEC_DEC;
    return DEC_HIT;
  endfunction

endpackage

// File: rtl/fmdll_win_sampler.sv
// Brings the clk_out-domain cycle count into clk_ext, captures it at each window
// end and classifies it against the target N one cycle later.
module fmdll_win_sampler
  import fmdll_pkg::*;
(
  input  logic       clk_ext,
  input  logic       rst,
  input  logic       i_en,
  input  logic [3:0] i_n,
  input  logic [1:0] i_m,
  input  logic [3:0] i_n_counter,
  input  logic [1:0] i_m_counter,
  output logic       o_dec_valid,
  output dec_e       o_dec
);

  logic [3:0] r_n_meta;
  logic [3:0] r_n_sync;
  logic [3:0] r_s;
  logic       r_dec_valid;
  logic       w_win_end;

  // A zero N or M would make the window meaningless, so it never ends.
  assign w_win_end = i_en && (i_m != 2'd0) && (i_n != 4'd0) && (i_m_counter == i_m);

  // NOTE: every register here is updated with <= so all flops sample the
  // pre-edge values; a blocking '=' would collapse the two sync stages into one.
  always_ff @(posedge clk_ext or posedge rst) begin
    if (rst) begin
      r_n_meta    <= '0;
      r_n_sync    <= '0;
      r_s         <= '0;
      r_dec_valid <= 1'b0;
    end else begin
      r_n_meta    <= i_n_counter;
      r_n_sync    <= r_n_meta;
      r_dec_valid <= w_win_end;
      if (w_win_end) r_s <= r_n_sync;
    end
  end

  assign o_dec_valid = r_dec_valid;
  assign o_dec       = classify(r_s, i_n);

endmodule

// File: rtl/fmdll_lock_ctrl.sv
// FMDLL delay-line lock controller: binary search, then +/-1 tracking, then lock.
// Optional FMDLL_LOCK_STAT_EN adds lock_loss_cnt (saturating count of LOCKED->TRACK exits).
module fmdll_lock_ctrl
  import fmdll_pkg::*;
#(
  parameter int CODE_W   = 6,
  parameter int SETTLE   = 2,
  parameter int LOCK_CNT = 4
) (
  input  logic              clk_ext,
  input  logic              rst,
  input  logic              en,
  input  logic [3:0]        N,
  input  logic [1:0]        M,
  input  logic [3:0]        N_counter,
  input  logic [1:0]        M_counter,
  output logic [CODE_W-1:0] dly_code,
  output logic [1:0]        state,
  output logic              locked
`ifdef FMDLL_LOCK_STAT_EN
  ,
  output logic [7:0]        lock_loss_cnt
`endif
);

  localparam int IDX_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;
  localparam int SET_W = $clog2(SETTLE + 1);
  localparam int HIT_W = $clog2(LOCK_CNT + 1);

  localparam logic [CODE_W-1:0] MID_CODE   = {1'b1, {(CODE_W-1){1'b0}}};
  localparam logic [IDX_W-1:0]  IDX_MSB    = IDX_W'(CODE_W - 1);
  localparam logic [SET_W-1:0]  SET_RELOAD = SET_W'(SETTLE - 1);
  localparam logic [HIT_W-1:0]  HIT_LAST   = HIT_W'(LOCK_CNT - 1);

  state_e            r_state, w_state_nxt;
  logic [CODE_W-1:0] r_code,   w_code_nxt, w_trial;
  logic [IDX_W-1:0]  r_idx,    w_idx_nxt;
  logic [SET_W-1:0]  r_settle, w_settle_nxt;
  logic [HIT_W-1:0]  r_hits,   w_hits_nxt;
  logic              r_locked;

  logic w_dec_valid;
  dec_e w_dec;
  logic w_use;

  fmdll_win_sampler u_sampler (
    .clk_ext     (clk_ext),
    .rst         (rst),
    .i_en        (en),
    .i_n         (N),
    .i_m         (M),
    .i_n_counter (N_counter),
    .i_m_counter (M_counter),
    .o_dec_valid (w_dec_valid),
    .o_dec       (w_dec)
  );

  // Only the SETTLE-th decision after a code change reflects the new code.
  assign w_use = w_dec_valid && (r_settle == '0);

  // NOTE: the asynchronous reset initialises every control register; nothing
  // relies on power-up values, so the loop always restarts from mid-scale.
  always_ff @(posedge clk_ext or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_code   <= MID_CODE;
      r_idx    <= '0;
      r_settle <= '0;
      r_hits   <= '0;
      r_locked <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_code   <= w_code_nxt;
      r_idx    <= w_idx_nxt;
      r_settle <= w_settle_nxt;
      r_hits   <= w_hits_nxt;
      r_locked <= (w_state_nxt == ST_LOCKED);
    end
  end

  // NOTE: every always_comb output gets a default first so no path can hold
  // a previous value, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    if (!en) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   w_state_nxt = ST_SEARCH;
        ST_SEARCH: if (w_use && r_idx == '0) w_state_nxt = ST_TRACK;
        ST_TRACK:  if (w_use && w_dec == DEC_HIT && r_hits == HIT_LAST) w_state_nxt = ST_LOCKED;
        ST_LOCKED: if (w_use && w_dec != DEC_HIT) w_state_nxt = ST_TRACK;
        default:   w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_code_nxt   = r_code;
    w_idx_nxt    = r_idx;
    w_hits_nxt   = r_hits;
    w_settle_nxt = (w_dec_valid && r_settle != '0) ? r_settle - 1'b1 : r_settle;
    w_trial      = r_code;
    if (!en || r_state == ST_IDLE) begin
      w_code_nxt   = MID_CODE;
      w_idx_nxt    = IDX_MSB;
      w_hits_nxt   = '0;
      w_settle_nxt = SET_RELOAD;
    end else if (w_use) begin
      case (r_state)
        ST_SEARCH: begin
          if (w_dec == DEC_DEC) w_trial[r_idx] = 1'b0;
          if (r_idx != '0) begin
            w_trial[r_idx - 1'b1] = 1'b1;
            w_idx_nxt             = r_idx - 1'b1;
          end else begin
            w_hits_nxt = '0;
          end
          if (w_trial != r_code) w_settle_nxt = SET_RELOAD;
          w_code_nxt = w_trial;
        end
        ST_TRACK, ST_LOCKED: begin
          if (w_dec == DEC_HIT) begin
            if (r_state == ST_TRACK) w_hits_nxt = r_hits + 1'b1;
          end else begin
            // Saturated steps leave the code alone but still restart settling.
            if (w_dec == DEC_INC)
              w_code_nxt = (r_code == '1) ? r_code : r_code + 1'b1;
            else
              w_code_nxt = (r_code == '0) ? r_code : r_code - 1'b1;
            w_hits_nxt   = '0;
            w_settle_nxt = SET_RELOAD;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FMDLL_LOCK_STAT_EN
  logic [7:0] r_loss_cnt;

  always_ff @(posedge clk_ext or posedge rst) begin
    if (rst)
      r_loss_cnt <= '0;
    else if (r_state == ST_LOCKED && w_state_nxt == ST_TRACK && r_loss_cnt != 8'hFF)
      r_loss_cnt <= r_loss_cnt + 1'b1;
  end

  assign lock_loss_cnt = r_loss_cnt;
`endif

  assign dly_code = r_code;
  assign state    = r_state;
  assign locked   = r_locked;

endmodule

// File: tb/tb_fmdll_lock_ctrl.sv
// Directed bench for fmdll_lock_ctrl: drives M_counter and a behavioural
// clk_out cycle count derived from dly_code, then checks the loop response.
module tb_fmdll_lock_ctrl;

  logic       clk_ext = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] N;
  logic [1:0] M;
  logic [3:0] N_counter;
  logic [1:0] M_counter;
  logic [5:0] dly_code;
  logic [1:0] state;
  logic       locked;
`ifdef FMDLL_LOCK_STAT_EN
  logic [7:0] lock_loss_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // 0: threshold model (8 cycles while code <= 41, else 7); 1: forced count
  int         n_mode  = 0;
  logic [3:0] n_force = 4'd8;

  fmdll_lock_ctrl dut (
    .clk_ext   (clk_ext),
    .rst       (rst),
    .en        (en),
    .N         (N),
    .M         (M),
    .N_counter (N_counter),
    .M_counter (M_counter),
    .dly_code  (dly_code),
    .state     (state),
    .locked    (locked)
`ifdef FMDLL_LOCK_STAT_EN
    ,
    .lock_loss_cnt (lock_loss_cnt)
`endif
  );

  always #5 clk_ext = ~clk_ext;

  // Window counter 1..M and the modelled clk_out count, updated away from posedge.
  initial begin
    M_counter = 2'd0;
    N_counter = 4'd0;
    forever begin
      @(negedge clk_ext);
      M_counter = (M_counter >= M) ? 2'd1 : M_counter + 2'd1;
      if (n_mode == 0) N_counter = (dly_code <= 6'd41) ? 4'd8 : 4'd7;
      else             N_counter = n_force;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sig(input int sel);
    case (sel)
      0:       return int'(dly_code);
      1:       return int'(state);
      default: return int'(locked);
    endcase
  endfunction

  // Waits (bounded) until the selected output equals target; reports cycles taken.
  task automatic wait_for(input string tag, input int sel, input int target,
                          input int budget, output int cyc);
    int v;
    cyc = 0;
    v   = sig(sel);
    while (v != target && cyc < budget) begin
      @(posedge clk_ext); #1;
      cyc++;
      v = sig(sel);
    end
    check(tag, v, target);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_ext);
    #1;
  endtask

  initial begin
    int cyc;
    int exp_codes[5] = '{48, 40, 44, 42, 41};

    // Reset with no clock edge yet
    rst = 1'b1; en = 1'b0; N = 4'd8; M = 2'd2;
    #2;
    check("rst_code",   dly_code, 32);
    check("rst_state",  state,    0);
    check("rst_locked", locked,   0);
    @(negedge clk_ext); rst = 1'b0;
    tick(3);
    check("idle_code", dly_code, 32);

    // Binary search: each bit costs SETTLE windows of M cycles = 4 cycles
    @(negedge clk_ext); en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_for($sformatf("search_code%0d", i), 0, exp_codes[i], 40, cyc);
      if (i > 0) check($sformatf("search_gap%0d", i), cyc, 4);
    end
    wait_for("search_done", 1, 2, 20, cyc);
    check("search_last_gap", cyc, 4);
    check("track_code", dly_code, 41);

    // Lock after LOCK_CNT used hits, never earlier than the 4th
    tick(7);
    check("early_locked", locked, 0);
    wait_for("lock_rise", 2, 1, 20, cyc);
    check("lock_state", state,    3);
    check("lock_code",  dly_code, 41);

    // Loss of lock on a too-fast window
    @(negedge clk_ext); n_mode = 1; n_force = 4'd9;
    wait_for("loss_fall", 2, 0, 20, cyc);
    check("loss_code",  dly_code, 42);
    check("loss_state", state,    2);
`ifdef FMDLL_LOCK_STAT_EN
    check("loss_cnt_1", lock_loss_cnt, 1);
`endif

    // Saturation at both ends of the code range
    @(negedge clk_ext); n_force = 4'd5;
    wait_for("down_to_0", 0, 0, 250, cyc);
    tick(12);
    check("sat_low",       dly_code, 0);
    check("sat_low_state", state,    2);
    @(negedge clk_ext); n_force = 4'd9;
    wait_for("up_to_63", 0, 63, 320, cyc);
    tick(12);
    check("sat_high",        dly_code, 63);
    check("sat_high_locked", locked,   0);

    // Asynchronous reset in the middle of tracking
    @(negedge clk_ext); #2; rst = 1'b1; #1;
    check("mid_rst_code",  dly_code, 32);
    check("mid_rst_state", state,    0);
    @(negedge clk_ext); rst = 1'b0; n_mode = 0;

    // Abort mid-search at bit index 3 (code 40), then restart from the MSB
    wait_for("abort_pre48", 0, 48, 40, cyc);
    wait_for("abort_pre40", 0, 40, 40, cyc);
    @(negedge clk_ext); en = 1'b0;
    @(posedge clk_ext); #1;
    check("abort_state", state,    0);
    check("abort_code",  dly_code, 32);
    tick(3);
    check("abort_hold", dly_code, 32);
    @(negedge clk_ext); en = 1'b1;
    wait_for("restart_msb", 0, 48, 40, cyc);
    check("restart_state", state, 1);

`ifdef FMDLL_LOCK_STAT_EN
    // Three lock/loss cycles from a fresh reset
    @(negedge clk_ext); rst = 1'b1; n_mode = 1; n_force = 4'd8;
    @(negedge clk_ext); rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_ext); n_force = 4'd8;
      wait_for($sformatf("stat_lock%0d", k), 2, 1, 100, cyc);
      @(negedge clk_ext); n_force = 4'd9;
      wait_for($sformatf("stat_loss%0d", k), 2, 0, 40, cyc);
    end
    check("stat_cnt", lock_loss_cnt, 3);
    @(negedge clk_ext); en = 1'b0;
    tick(3);
    @(negedge clk_ext); en = 1'b1;
    tick(3);
    check("stat_cnt_en_toggle", lock_loss_cnt, 3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
